// File: rtl/bram_stream_reader_pkg.sv
// ---------------------------------------------------------------------------
// bram_stream_reader_pkg
//   Shared constants for the GEMM memory subsystem plus the types used by the
//   BRAM stream reader.
//   Memories:
//     mem0 : im2col input feature map, LANES x DATA_WIDTH bit words
//     mem1 : reshaped weights, same geometry as mem0
//     mem2 : accumulator results, LANES x ACC_WIDTH bit words
// ---------------------------------------------------------------------------
package bram_stream_reader_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int LANES      = 14;
  localparam int ACC_WIDTH  = 32;

  localparam int MEM0_DATA_WIDTH = DATA_WIDTH * LANES;
  localparam int MEM0_ADDR_WIDTH = 13;
  localparam int MEM0_DEPTH      = 4116;

  localparam int MEM1_DATA_WIDTH = DATA_WIDTH * LANES;
  localparam int MEM1_ADDR_WIDTH = 13;
  localparam int MEM1_DEPTH      = 4116;

  localparam int MEM2_DATA_WIDTH = ACC_WIDTH * LANES;
  localparam int MEM2_ADDR_WIDTH = 13;
  localparam int MEM2_DEPTH      = 4116;

  // Width of the output FIFO occupancy count (0, 1 or 2 entries).
  localparam int FIFO_CNT_W = 2;

  // Reader control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rdState_e;

endpackage

// File: rtl/bram_stream_reader_fifo2_reg.sv
// ---------------------------------------------------------------------------
// fifo2_reg
//   Two-entry register FIFO holding a data word and its last flag. Entry 0 is
//   always the head, so the head outputs come straight from flops.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     push_i        write pushData_i/pushLast_i this cycle
//     pushData_i    word to store
//     pushLast_i    last flag to store with the word
//     pop_i         remove the head entry (ignored when empty)
//     count_o       number of valid entries, 0..2
//     headData_o    head word (all zeros after reset)
//     headLast_o    head last flag
// ---------------------------------------------------------------------------
module fifo2_reg
  import bram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 112
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      pushData_i,
  input  logic                  pushLast_i,
  input  logic                  pop_i,
  output logic [FIFO_CNT_W-1:0] count_o,
  output logic [WIDTH-1:0]      headData_o,
  output logic                  headLast_o
);

  logic [WIDTH-1:0]      data0_q, data0_d, data1_q, data1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  doPop;

  // Next-state logic. A push while full without a pop is dropped; the
  // reader's issue rule guarantees that case never arises. Push and pop on a
  // full FIFO shift the tail into the head and refill the tail.
  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    count_d = count_q;
    doPop   = pop_i && (count_q != 2'd0);
    case ({push_i, doPop})
      2'b10: begin
        if (count_q == 2'd0) begin
          data0_d = pushData_i;
          last0_d = pushLast_i;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          data1_d = pushData_i;
          last1_d = pushLast_i;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          data0_d = pushData_i;
          last0_d = pushLast_i;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = pushData_i;
          last1_d = pushLast_i;
        end
      end
      default: ;
    endcase
  end

  // Storage registers; reset clears data too so the stream word reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      count_q <= '0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign headData_o = data0_q;
  assign headLast_o = last0_q;

endmodule

// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
//   Reads len_i consecutive words from BRAM port 0 (1-cycle registered read)
//   starting at base_addr_i, wrapping modulo MEM_SIZE, and presents them as a
//   valid/ready stream with a last flag. Sustains one word per clock and
//   tolerates any backpressure via a 2-entry output FIFO.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     start_i       launch a transfer (only looked at while idle)
//     base_addr_i   first word address, captured with start_i
//     len_i         number of words, 0..MEM_SIZE, captured with start_i
//     busy_o        transfer in progress (READ or DRAIN)
//     done_o        one-cycle pulse after the final beat is accepted
//     addr0_o       BRAM port-0 address
//     ce0_o         BRAM port-0 chip enable, high when a read is issued
//     we0_o         BRAM port-0 write enable, tied low
//     q0_i          BRAM port-0 read data, valid the cycle after ce0_o
//     m_valid_o     stream valid
//     m_ready_i     stream ready
//     m_data_o      stream word; lane 0 sits in the top byte
//     m_last_o      final word of the transfer
// ---------------------------------------------------------------------------
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int DWIDTH   = MEM0_DATA_WIDTH,
  parameter int AWIDTH   = MEM0_ADDR_WIDTH,
  parameter int MEM_SIZE = MEM0_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] base_addr_i,
  input  logic [AWIDTH-1:0] len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [AWIDTH-1:0] addr0_o,
  output logic              ce0_o,
  output logic              we0_o,
  input  logic [DWIDTH-1:0] q0_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DWIDTH-1:0] m_data_o,
  output logic              m_last_o
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);
  localparam logic [AWIDTH-1:0] ONE_ADDR  = AWIDTH'(1);
  localparam logic [AWIDTH:0]   ONE_CNT   = (AWIDTH + 1)'(1);

  rdState_e              state_q;
  logic [AWIDTH-1:0]     addr_q;
  logic [AWIDTH:0]       rdLeft_q;
  logic                  inflight_q;
  logic                  inflightLast_q;
  logic                  busy_q;
  logic                  done_q;

  logic [FIFO_CNT_W-1:0] fifoCount;
  logic                  fifoHeadLast;
  logic [DWIDTH-1:0]     fifoHeadData;
  logic                  pop;
  logic                  issue;
  logic                  lastIssue;
  logic [2:0]            occ;
  logic [AWIDTH-1:0]     addrNext;

  // Issue decision: words owed to the FIFO (stored plus the one in flight)
  // minus the one leaving this cycle must leave room for one more. Using the
  // current pop keeps full throughput with ready held high, at the cost of a
  // combinational path from m_ready_i to ce0_o.
  assign m_valid_o = (fifoCount != 2'd0);
  assign pop       = m_valid_o & m_ready_i;
  assign occ       = {1'b0, fifoCount} + {2'b00, inflight_q};
  assign issue     = (state_q == ST_READ) && (occ <= (3'd1 + {2'b00, pop}));
  assign lastIssue = issue && (rdLeft_q == ONE_CNT);
  assign addrNext  = (addr_q == LAST_ADDR) ? '0 : (addr_q + ONE_ADDR);

  // Control FSM with registered busy/done. The address is not advanced past
  // the final read, so addr0_o keeps showing the last word fetched. Reset
  // clears the in-flight flag, which discards any read still in the BRAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      rdLeft_q       <= '0;
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      inflight_q     <= issue;
      inflightLast_q <= lastIssue;
      done_q         <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              state_q  <= ST_READ;
              busy_q   <= 1'b1;
              addr_q   <= base_addr_i;
              rdLeft_q <= {1'b0, len_i};
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            rdLeft_q <= rdLeft_q - ONE_CNT;
            if (lastIssue) begin
              state_q <= ST_DRAIN;
            end else begin
              addr_q <= addrNext;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && fifoHeadLast) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  fifo2_reg #(
    .WIDTH(DWIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .pushData_i (q0_i),
    .pushLast_i (inflightLast_q),
    .pop_i      (pop),
    .count_o    (fifoCount),
    .headData_o (fifoHeadData),
    .headLast_o (fifoHeadLast)
  );

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign addr0_o  = addr_q;
  assign ce0_o    = issue;
  assign we0_o    = 1'b0;
  assign m_data_o = fifoHeadData;
  assign m_last_o = fifoHeadLast;

endmodule

// File: tb/tb_bram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_bram_stream_reader
//   Drives bram_stream_reader against a behavioural dual-port BRAM (port 1
//   used for preloading) and scores the stream against expected words queued
//   at start time.
// ---------------------------------------------------------------------------
module tb_bram_stream_reader;

  localparam int DW = 112;
  localparam int AW = 13;
  localparam int MS = 4116;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW-1:0] len = '0;
  logic          busy, done, ce0, we0, mValid, mLast;
  logic          mReady = 1'b0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] q0 = '0;
  logic [DW-1:0] mData;

  logic [DW-1:0] mem [0:MS-1];
  logic          we1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] d1 = '0;

  int total = 0;
  int bad = 0;
  int badAddr = 0;
  int occErr = 0;
  int issuedTot = 0;
  int poppedTot = 0;

  logic          sValid, sLast, sDone, sBusy, sCe, sWe, sReady;
  logic [DW-1:0] sData;
  logic [AW-1:0] sAddr;

  beat_t expQ[$];
  int    addrQ[$];

  always #5 clk = ~clk;

  bram_stream_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .base_addr_i (base),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .addr0_o     (addr0),
    .ce0_o       (ce0),
    .we0_o       (we0),
    .q0_i        (q0),
    .m_valid_o   (mValid),
    .m_ready_i   (mReady),
    .m_data_o    (mData),
    .m_last_o    (mLast)
  );

  // Behavioural true dual-port BRAM: port 1 loads, port 0 reads with one
  // cycle of latency.
  always @(posedge clk) begin
    if (we1) mem[addr1] <= d1;
    if (ce0) q0 <= (int'(addr0) < MS) ? mem[addr0] : '0;
  end

  // Watches for illegal addresses and for reads issued beyond FIFO space.
  always @(negedge clk) begin
    if (rst) begin
      issuedTot = 0;
      poppedTot = 0;
    end else begin
      if (ce0 && int'(addr0) >= MS) badAddr++;
      issuedTot += int'(ce0);
      poppedTot += int'(mValid && mReady);
      if (issuedTot - poppedTot > 2) occErr++;
    end
  end

  function automatic logic [DW-1:0] patt(input int a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E37_79B1;
    return {16'(a), h, ~h, h ^ 32'h5A5A_5A5A};
  endfunction

  task automatic pushExpected(input int b, input int n);
    beat_t bt;
    for (int i = 0; i < n; i++) begin
      bt.data = patt((b + i) % MS);
      bt.last = (i == n - 1);
      expQ.push_back(bt);
    end
  endtask

  task automatic stepCycle(input logic rdy);
    mReady = rdy;
    @(negedge clk);
    sValid = mValid; sData = mData; sLast = mLast; sDone = done;
    sBusy = busy; sCe = ce0; sWe = we0; sAddr = addr0; sReady = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic loadMem();
    for (int a = 0; a < MS; a++) begin
      addr1 = AW'(a);
      d1 = patt(a);
      we1 = 1'b1;
      @(posedge clk);
      #1;
    end
    we1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stepCycle(1'b0);
    stepCycle(1'b1);
    total++;
    if ({sBusy, sDone, sCe, sWe, sValid, sLast} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b want 000000", {sBusy, sDone, sCe, sWe, sValid, sLast});
    end
    total++;
    if (sAddr !== '0 || sData !== '0) begin
      bad++;
      $display("[TB] FAIL reset_addr_data: got addr=%0d data=%h want 0", sAddr, sData);
    end
    rst = 1'b0;
    stepCycle(1'b1);
  endtask

  task automatic test_basic();
    int beats, doneAt, doneCnt, firstBeat, lastAt;
    beat_t e;
    beats = 0; doneAt = -1; doneCnt = 0; firstBeat = -1; lastAt = -1;
    pushExpected(0, 4);
    base = 0; len = 4; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      stepCycle(1'b1);
      start = 1'b0;
      if (k == 1) begin
        total++;
        if (sCe !== 1'b1 || sAddr !== '0) begin
          bad++;
          $display("[TB] FAIL basic_first_read: got ce=%b addr=%0d want ce=1 addr=0", sCe, sAddr);
        end
      end
      if (sValid && sReady) begin
        if (firstBeat < 0) firstBeat = k;
        if (sLast) lastAt = k;
        beats++;
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL basic_extra_beat: got beat at %0d want none", k);
        end else begin
          e = expQ.pop_front();
          if (sData !== e.data || sLast !== e.last) begin
            bad++;
            $display("[TB] FAIL basic_beat: got %h/%b want %h/%b", sData, sLast, e.data, e.last);
          end
        end
      end
      if (sDone === 1'b1) begin
        doneCnt++;
        if (doneAt < 0) doneAt = k;
      end
    end
    total++;
    if (firstBeat != 3 || lastAt != 6 || beats != 4) begin
      bad++;
      $display("[TB] FAIL basic_timing: got first=%0d last=%0d beats=%0d want 3 6 4", firstBeat, lastAt, beats);
    end
    total++;
    if (doneAt != 7 || doneCnt != 1) begin
      bad++;
      $display("[TB] FAIL basic_done: got at=%0d cnt=%0d want at=7 cnt=1", doneAt, doneCnt);
    end
  endtask

  task automatic test_wrap();
    int doneCnt, a;
    beat_t e;
    doneCnt = 0;
    expQ.delete();
    addrQ.delete();
    pushExpected(4110, 10);
    for (int i = 0; i < 10; i++) addrQ.push_back((4110 + i) % MS);
    base = AW'(4110); len = AW'(10); start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      stepCycle(1'b1);
      start = 1'b0;
      if (sCe) begin
        total++;
        if (addrQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL wrap_extra_read: got addr=%0d want no read", sAddr);
        end else begin
          a = addrQ.pop_front();
          if (sAddr !== AW'(a)) begin
            bad++;
            $display("[TB] FAIL wrap_addr: got %0d want %0d", sAddr, a);
          end
        end
      end
      if (sValid && sReady) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL wrap_extra_beat: got beat at %0d want none", k);
        end else begin
          e = expQ.pop_front();
          if (sData !== e.data || sLast !== e.last) begin
            bad++;
            $display("[TB] FAIL wrap_beat: got %h/%b want %h/%b", sData, sLast, e.data, e.last);
          end
        end
      end
      if (sDone === 1'b1) doneCnt++;
    end
    total++;
    if (expQ.size() != 0 || addrQ.size() != 0 || badAddr != 0 || doneCnt != 1) begin
      bad++;
      $display("[TB] FAIL wrap_summary: got left=%0d/%0d badAddr=%0d done=%0d want 0/0 0 1",
               expQ.size(), addrQ.size(), badAddr, doneCnt);
    end
  endtask

  task automatic test_backpressure();
    int doneCnt, beats, burstAt;
    logic rdy, prevValid, prevReady, prevLast;
    logic [DW-1:0] prevData;
    beat_t e;
    doneCnt = 0; beats = 0; prevValid = 1'b0; prevReady = 1'b0; prevLast = 1'b0; prevData = '0;
    burstAt = int'($urandom_range(4, 12));
    expQ.delete();
    pushExpected(100, 16);
    base = AW'(100); len = AW'(16); start = 1'b1;
    for (int k = 0; k < 80; k++) begin
      rdy = (k >= burstAt && k < burstAt + 5) ? 1'b0 : (k % 2 == 0);
      stepCycle(rdy);
      start = 1'b0;
      if (prevValid && !prevReady) begin
        total++;
        if (sValid !== 1'b1 || sData !== prevData || sLast !== prevLast) begin
          bad++;
          $display("[TB] FAIL bp_hold: got %b/%h/%b want 1/%h/%b", sValid, sData, sLast, prevData, prevLast);
        end
      end
      if (sValid && sReady) begin
        beats++;
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL bp_extra_beat: got beat at %0d want none", k);
        end else begin
          e = expQ.pop_front();
          if (sData !== e.data || sLast !== e.last) begin
            bad++;
            $display("[TB] FAIL bp_beat: got %h/%b want %h/%b", sData, sLast, e.data, e.last);
          end
        end
      end
      if (sDone === 1'b1) doneCnt++;
      prevValid = sValid; prevReady = sReady; prevData = sData; prevLast = sLast;
    end
    total++;
    if (beats != 16 || expQ.size() != 0 || doneCnt != 1 || occErr != 0) begin
      bad++;
      $display("[TB] FAIL bp_summary: got beats=%0d left=%0d done=%0d occErr=%0d want 16 0 1 0",
               beats, expQ.size(), doneCnt, occErr);
    end
  endtask

  task automatic test_zero_len();
    int doneAt, doneCnt, anyCe, anyValid, anyBusy;
    doneAt = -1; doneCnt = 0; anyCe = 0; anyValid = 0; anyBusy = 0;
    base = AW'(7); len = '0; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      stepCycle(1'b1);
      start = 1'b0;
      if (sDone === 1'b1) begin
        doneCnt++;
        if (doneAt < 0) doneAt = k;
      end
      anyCe += int'(sCe);
      anyValid += int'(sValid);
      anyBusy += int'(sBusy);
    end
    total++;
    if (doneAt != 1 || doneCnt != 1) begin
      bad++;
      $display("[TB] FAIL zero_done: got at=%0d cnt=%0d want at=1 cnt=1", doneAt, doneCnt);
    end
    total++;
    if (anyCe != 0 || anyValid != 0 || anyBusy != 0) begin
      bad++;
      $display("[TB] FAIL zero_quiet: got ce=%0d valid=%0d busy=%0d want 0 0 0", anyCe, anyValid, anyBusy);
    end
  endtask

  task automatic test_reset_mid();
    int beats, strayValid, doneCnt;
    beat_t e;
    beats = 0; strayValid = 0; doneCnt = 0;
    expQ.delete();
    pushExpected(200, 20);
    base = AW'(200); len = AW'(20); start = 1'b1;
    for (int k = 0; k < 30 && beats < 7; k++) begin
      stepCycle(1'b1);
      start = 1'b0;
      if (sValid && sReady) begin
        beats++;
        total++;
        e = expQ.pop_front();
        if (sData !== e.data || sLast !== e.last) begin
          bad++;
          $display("[TB] FAIL rmid_beat: got %h/%b want %h/%b", sData, sLast, e.data, e.last);
        end
      end
    end
    total++;
    if (beats != 7) begin
      bad++;
      $display("[TB] FAIL rmid_reach: got beats=%0d want 7", beats);
    end
    rst = 1'b1;
    stepCycle(1'b0);
    rst = 1'b0;
    stepCycle(1'b1);
    total++;
    if ({sBusy, sDone, sCe, sValid, sLast} !== 5'b0 || sAddr !== '0 || sData !== '0) begin
      bad++;
      $display("[TB] FAIL rmid_zero: got ctrl=%b addr=%0d data=%h want all 0",
               {sBusy, sDone, sCe, sValid, sLast}, sAddr, sData);
    end
    for (int k = 0; k < 8; k++) begin
      stepCycle(1'b1);
      strayValid += int'(sValid) + int'(sCe) + int'(sDone);
    end
    total++;
    if (strayValid != 0) begin
      bad++;
      $display("[TB] FAIL rmid_stray: got %0d stray events want 0", strayValid);
    end
    expQ.delete();
    beats = 0;
    pushExpected(3000, 5);
    base = AW'(3000); len = AW'(5); start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      stepCycle(1'b1);
      start = 1'b0;
      if (sValid && sReady) begin
        beats++;
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL rmid_new_extra: got beat at %0d want none", k);
        end else begin
          e = expQ.pop_front();
          if (sData !== e.data || sLast !== e.last) begin
            bad++;
            $display("[TB] FAIL rmid_new_beat: got %h/%b want %h/%b", sData, sLast, e.data, e.last);
          end
        end
      end
      if (sDone === 1'b1) doneCnt++;
    end
    total++;
    if (beats != 5 || doneCnt != 1) begin
      bad++;
      $display("[TB] FAIL rmid_new_summary: got beats=%0d done=%0d want 5 1", beats, doneCnt);
    end
  endtask

  task automatic test_start_while_busy();
    int beats, doneCnt;
    beat_t e;
    beats = 0; doneCnt = 0;
    expQ.delete();
    pushExpected(50, 6);
    base = AW'(50); len = AW'(6);
    for (int k = 0; k < 16; k++) begin
      start = (k == 0 || k == 2 || k == 4);
      if (k != 0) begin
        base = AW'(1000);
        len = AW'(3);
      end
      stepCycle(1'b1);
      if (sValid && sReady) begin
        beats++;
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL busy_extra_beat: got beat at %0d want none", k);
        end else begin
          e = expQ.pop_front();
          if (sData !== e.data || sLast !== e.last) begin
            bad++;
            $display("[TB] FAIL busy_beat: got %h/%b want %h/%b", sData, sLast, e.data, e.last);
          end
        end
      end
      if (sDone === 1'b1) doneCnt++;
    end
    start = 1'b0;
    total++;
    if (beats != 6 || doneCnt != 1) begin
      bad++;
      $display("[TB] FAIL busy_summary: got beats=%0d done=%0d want 6 1", beats, doneCnt);
    end
  endtask

  initial begin
    $display("[TB] preloading BRAM through port 1");
    loadMem();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
